lif_potential_unit: RTL
=======================

Name: lif_potential_unit

Overview:
- Leaky integrate-and-fire membrane stage that sits directly downstream of the synaptic weight accumulator (mac).
- Consumes IEEE-754 single-precision accumulated weights through a valid/ready handshake.
- At each timestep end it applies leak, compares the potential against the threshold, and emits a spike carrying the neuron address toward the NoC router interface.
- Uses the codebase's combinational Addition_Subtraction float adder, one shared instance.

Parameters:
- ADDR_W, 12, neuron/source address width.
- REFRACTORY_STEPS, 2, timesteps during which incoming weights are discarded after a spike (0 disables refractory).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- neuron_address  in  ADDR_W  address stamped on emitted spikes.
- init_valid  in  1  one-cycle pulse; loads the three config words below.
- init_threshold  in  32  firing threshold (float, must be positive).
- init_leak  in  32  leak subtracted per timestep (float, non-negative).
- init_reset_potential  in  32  potential after firing (float, non-negative).
- in_valid  in  1  accumulated weight available.
- in_weight  in  32  accumulated weight (float).
- in_ready  out  1  weight accepted when in_valid && in_ready.
- timestep_end  in  1  one-cycle pulse marking the end of a timestep.
- spike_valid  out  1  spike pending.
- spike_ready  in  1  downstream accepts spike.
- spike_address  out  ADDR_W  neuron_address captured at fire.
- membrane_potential  out  32  current potential register.
- ts_overrun  out  1  sticky: timestep_end arrived while one was already pending.
- add_exception  out  1  sticky: the adder flagged an exception.

Behaviour:
- Reset values:
  - State IDLE; potential 0x00000000.
  - threshold 0x3F800000; leak 0; reset_potential 0.
  - Refractory counter 0; pending flag 0.
  - spike_valid 0; spike_address 0; ts_overrun 0; add_exception 0.
- Reset is honoured in any state, including mid-ADD or mid-FIRE.
- in_ready = (state==IDLE) && !timestep_end && !ts_pending && !init_valid (combinational).
- init_valid, any state, highest priority:
  - Load the config words and set potential to init_reset_potential.
  - Clear the refractory counter and pending flag, drop spike_valid, go to IDLE.
- State machine:
  - IDLE:
    - On accept, register the weight and go to ADD.
    - Else, on timestep_end or ts_pending, clear pending and go to LEAK.
  - ADD, 1 cycle:
    - If refractory counter is 0, potential <= potential + weight.
    - Else the weight is discarded and potential is unchanged.
    - Return to IDLE.
    - Single-throughput: one weight per 2 cycles.
  - LEAK, 1 cycle:
    - potential <= potential - leak.
    - If the result's sign bit is 1, clamp to +0.0 (0x00000000).
    - Go to CHECK.
  - CHECK, 1 cycle:
    - If refractory counter > 0: decrement it and go to IDLE.
    - Else if potential[30:0] >= threshold[30:0] (valid because both are non-negative): capture spike_address, set spike_valid, set potential <= reset_potential, load counter with REFRACTORY_STEPS, go to FIRE.
    - Else go to IDLE.
  - FIRE:
    - Hold spike_valid and spike_address stable until spike_ready.
    - On handshake, clear spike_valid the next cycle and go to IDLE.
- timestep_end arriving outside IDLE, or in IDLE together with an in-flight pending:
  - Set ts_pending.
  - If ts_pending is already set, set ts_overrun. The extra event is dropped.
- Latency: timestep_end in IDLE gives spike_valid 3 cycles later (LEAK, CHECK, FIRE entry).
- An exception from the adder in ADD or LEAK sets add_exception. The result is still written.
- membrane_potential mirrors the register.

Test Plan:
- Reset mid-ADD -> next cycle potential 0, in_ready 1, spike_valid 0, state IDLE.
- Threshold 1.0, leak 0.25 (0x3E800000); weights 0x3F000000 twice, then timestep_end -> potential 0x3F400000, no spike.
- Leak 0, neuron_address 0x00A; weights 0.5 then 0.75, then timestep_end:
  - spike_valid asserts 3 cycles later, spike_address 0x00A, potential 0.
  - Hold spike_ready low 5 cycles -> spike_valid stays 1 and in_ready stays 0.
  - Raise spike_ready -> spike_valid drops the following cycle.
- REFRACTORY_STEPS=2: after a spike, weight 1.5 (0x3FC00000) in each of the next two timesteps:
  - Those weights are accepted but potential stays 0 with no spike.
  - In the third timestep, weight 1.5 fires.
- Leak 0.25 with potential 0, then timestep_end -> potential 0x00000000 (not 0xBE800000).
- timestep_end and in_valid in the same IDLE cycle -> in_ready 0 that cycle; the weight is accepted after CHECK and contributes to the next timestep.
- Two timestep_end pulses during FIRE -> ts_overrun 1, and only one LEAK runs after the spike handshake.

Source files
------------

// File: rtl/lif_potential_unit.sv
// lif_potential_unit: leaky integrate-and-fire membrane stage with a shared float adder,
// refractory window and spike handshake toward the NoC router.

module Addition_Subtraction (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_result,
  output logic        o_exception
);
  logic [31:0] w_b;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [23:0] w_mbig;
  logic [23:0] w_msmall;
  logic [7:0]  w_diff;
  logic [26:0] w_xbig;
  logic [26:0] w_xsmall;
  logic [26:0] w_aligned;
  logic        w_sticky;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [26:0] w_norm;
  logic signed [9:0] w_exp;
  logic signed [9:0] w_e1;
  logic signed [9:0] w_ef;
  logic        w_up;
  logic [24:0] w_rnd;
  logic [22:0] w_mant;
  logic        w_inf_in;
  logic        w_zero;
  logic        w_ovf;
  always_comb begin
    w_b = {i_b[31] ^ i_sub, i_b[30:0]};
    {w_big, w_small} = (i_a[30:0] < w_b[30:0]) ? {w_b, i_a} : {i_a, w_b};
    // subnormal operands are flushed to zero
    w_mbig = (|w_big[30:23]) ? {1'b1, w_big[22:0]} : 24'd0;
    w_msmall = (|w_small[30:23]) ? {1'b1, w_small[22:0]} : 24'd0;
    w_diff = w_big[30:23] - w_small[30:23];
    w_xbig = {w_mbig, 3'b000};
    w_xsmall = {w_msmall, 3'b000};
    w_sticky = (w_diff > 8'd26) ? |w_xsmall : |(w_xsmall & ~(27'h7FFFFFF << w_diff));
    w_aligned = ((w_diff > 8'd26) ? 27'd0 : (w_xsmall >> w_diff)) | {26'd0, w_sticky};
    w_sum = (w_big[31] == w_small[31]) ? {1'b0, w_xbig} + {1'b0, w_aligned}
                                       : {1'b0, w_xbig} - {1'b0, w_aligned};
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (w_sum[i]) w_lz = 5'(26 - i);
    w_norm = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : (w_sum[26:0] << w_lz);
    w_exp = $signed({2'b00, w_big[30:23]});
    w_e1 = w_sum[27] ? w_exp + 10'sd1 : w_exp - $signed({5'd0, w_lz});
    w_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_up};
    w_ef = w_rnd[24] ? w_e1 + 10'sd1 : w_e1;
    w_mant = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    w_inf_in = (&i_a[30:23]) | (&i_b[30:23]);
    w_zero = (w_sum == 28'd0) || (w_ef < 10'sd1);
    w_ovf = !w_zero && (w_ef > 10'sd254);
    o_exception = w_inf_in | w_ovf;
    o_result = o_exception ? {w_big[31], 8'hFF, 23'd0}
             : w_zero      ? 32'd0
             :               {w_big[31], w_ef[7:0], w_mant};
  end
endmodule

module lif_potential_unit #(
  parameter int ADDR_W = 12,
  parameter int REFRACTORY_STEPS = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] neuron_address,
  input  logic              init_valid,
  input  logic [31:0]       init_threshold,
  input  logic [31:0]       init_leak,
  input  logic [31:0]       init_reset_potential,
  input  logic              in_valid,
  input  logic [31:0]       in_weight,
  output logic              in_ready,
  input  logic              timestep_end,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic [ADDR_W-1:0] spike_address,
  output logic [31:0]       membrane_potential,
  output logic              ts_overrun,
  output logic              add_exception
);
  localparam int CW = (REFRACTORY_STEPS > 0) ? $clog2(REFRACTORY_STEPS + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_LEAK, S_CHECK, S_FIRE} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_potential, w_pot_nxt;
  logic [31:0]       r_threshold, w_thr_nxt;
  logic [31:0]       r_leak, w_leak_nxt;
  logic [31:0]       r_reset_pot, w_rp_nxt;
  logic [31:0]       r_weight, w_weight_nxt;
  logic [CW-1:0]     r_refr, w_refr_nxt;
  logic              r_pending, w_pend_nxt;
  logic              r_spike_valid, w_sv_nxt;
  logic [ADDR_W-1:0] r_spike_addr, w_sa_nxt;
  logic              r_overrun, w_ovr_nxt;
  logic              r_exc, w_exc_nxt;
  logic              w_sub;
  logic [31:0]       w_sum;
  logic              w_add_exc;
  logic              w_accept;

  assign w_sub = (r_state == S_LEAK);
  assign in_ready = (r_state == S_IDLE) && !timestep_end && !r_pending && !init_valid;
  assign w_accept = in_valid && in_ready;
  assign spike_valid = r_spike_valid;
  assign spike_address = r_spike_addr;
  assign membrane_potential = r_potential;
  assign ts_overrun = r_overrun;
  assign add_exception = r_exc;

  Addition_Subtraction u_add (
    .i_a        (r_potential),
    .i_b        (w_sub ? r_leak : r_weight),
    .i_sub      (w_sub),
    .o_result   (w_sum),
    .o_exception(w_add_exc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pot_nxt = r_potential;
    w_thr_nxt = r_threshold;
    w_leak_nxt = r_leak;
    w_rp_nxt = r_reset_pot;
    w_weight_nxt = r_weight;
    w_refr_nxt = r_refr;
    w_pend_nxt = r_pending;
    w_sv_nxt = r_spike_valid;
    w_sa_nxt = r_spike_addr;
    w_ovr_nxt = r_overrun;
    w_exc_nxt = r_exc;
    if (init_valid) begin
      w_thr_nxt = init_threshold;
      w_leak_nxt = init_leak;
      w_rp_nxt = init_reset_potential;
      w_pot_nxt = init_reset_potential;
      w_refr_nxt = '0;
      w_pend_nxt = 1'b0;
      w_sv_nxt = 1'b0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_weight_nxt = in_weight;
            w_state_nxt = S_ADD;
          end else if (timestep_end || r_pending) begin
            // a fresh event colliding with a queued one is dropped
            w_ovr_nxt = r_overrun | (timestep_end & r_pending);
            w_pend_nxt = 1'b0;
            w_state_nxt = S_LEAK;
          end
        end
        S_ADD: begin
          w_pot_nxt = (r_refr == '0) ? w_sum : r_potential;
          w_exc_nxt = r_exc | ((r_refr == '0) & w_add_exc);
          w_state_nxt = S_IDLE;
        end
        S_LEAK: begin
          w_pot_nxt = w_sum[31] ? 32'd0 : w_sum;
          w_exc_nxt = r_exc | w_add_exc;
          w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (r_refr != '0) begin
            w_refr_nxt = r_refr - 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_potential[30:0] >= r_threshold[30:0]) begin
            w_sa_nxt = neuron_address;
            w_sv_nxt = 1'b1;
            w_pot_nxt = r_reset_pot;
            w_refr_nxt = CW'(REFRACTORY_STEPS);
            w_state_nxt = S_FIRE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FIRE: begin
          w_sv_nxt = spike_ready ? 1'b0 : r_spike_valid;
          w_state_nxt = spike_ready ? S_IDLE : S_FIRE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (timestep_end && r_state != S_IDLE) begin
        w_pend_nxt = 1'b1;
        w_ovr_nxt = r_overrun | r_pending;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_potential <= 32'h00000000;
      r_threshold <= 32'h3F800000;
      r_leak <= 32'h00000000;
      r_reset_pot <= 32'h00000000;
      r_weight <= 32'h00000000;
      r_refr <= '0;
      r_pending <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_addr <= '0;
      r_overrun <= 1'b0;
      r_exc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_potential <= w_pot_nxt;
      r_threshold <= w_thr_nxt;
      r_leak <= w_leak_nxt;
      r_reset_pot <= w_rp_nxt;
      r_weight <= w_weight_nxt;
      r_refr <= w_refr_nxt;
      r_pending <= w_pend_nxt;
      r_spike_valid <= w_sv_nxt;
      r_spike_addr <= w_sa_nxt;
      r_overrun <= w_ovr_nxt;
      r_exc <= w_exc_nxt;
    end
  end
endmodule
